// File: rtl/prog_moore_fsm_pkg.sv
// Shared definitions for the programmable Moore FSM: config-select
// encodings and a width helper for the config data bus.
package prog_fsm_pkg;

   // cfg_sel encodings: which table a config write targets
   localparam logic CFG_SEL_NEXT = 1'b0;
   localparam logic CFG_SEL_OUT  = 1'b1;

   // Wider of two widths; sizes cfg_data so it carries either a state or an output
   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/prog_moore_fsm_if.sv
// Configuration write bus of the programmable Moore FSM.
// The master drives table writes; the FSM is the slave.
interface prog_moore_fsm_if
   import prog_fsm_pkg::*;
#(
   parameter int STATE_W = 2,
   parameter int IN_W    = 1,
   parameter int OUT_W   = 1
) ();

   localparam int DATA_W = max_w(STATE_W, OUT_W);

   logic               cfg_we;
   logic               cfg_sel;
   logic [STATE_W-1:0] cfg_state;
   logic [IN_W-1:0]    cfg_sym;
   logic [DATA_W-1:0]  cfg_data;

   modport master (
      output cfg_we, cfg_sel, cfg_state, cfg_sym, cfg_data
   );

   modport slave (
      input cfg_we, cfg_sel, cfg_state, cfg_sym, cfg_data
   );

endinterface

// File: rtl/prog_moore_fsm_table.sv
// Next-state and output tables of the programmable Moore FSM.
// One range-checked write port with a sticky error flag; two
// asynchronous read ports (next entry by state/symbol, output by state).
module prog_fsm_table
   import prog_fsm_pkg::*;
#(
   parameter int STATE_W    = 2,
   parameter int NUM_STATES = 4,
   parameter int IN_W       = 1,
   parameter int OUT_W      = 1,
   parameter int INIT_STATE = 0,
   parameter int DATA_W     = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               sel,
   input  logic [STATE_W-1:0] wr_state,
   input  logic [IN_W-1:0]    wr_sym,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic [STATE_W-1:0] rd_state,
   input  logic [IN_W-1:0]    rd_sym,
   output logic [STATE_W-1:0] rd_next,
   output logic [OUT_W-1:0]   rd_out,
   output logic               err
);

   localparam int                 ROWS = 2 ** STATE_W;
   localparam int                 SYMS = 2 ** IN_W;
   localparam logic [STATE_W:0]   NS   = (STATE_W + 1)'(NUM_STATES);
   localparam logic [STATE_W-1:0] INIT = STATE_W'(INIT_STATE);

   logic [STATE_W-1:0] next_mem [ROWS][SYMS];
   logic [OUT_W-1:0]   out_mem  [ROWS];

   logic               state_ok;
   logic               data_ok;
   logic               wr_ok;
   logic [ROWS-1:0]    row_hit;

   // A write is legal only for an existing row, and a next-state write
   // must also name an existing state; this keeps the FSM out of illegal states.
   assign state_ok = ({1'b0, wr_state} < NS);
   assign data_ok  = (sel == CFG_SEL_OUT) || ({1'b0, wr_data[STATE_W-1:0]} < NS);
   assign wr_ok    = state_ok && data_ok;

   // Per-row write strobe for an accepted write
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_hit
         assign row_hit[gi] = we && wr_ok && (wr_state == STATE_W'(gi));
      end
   endgenerate

   // Table storage: reset to "every edge goes to INIT, every output 0"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < ROWS; r++) begin
            out_mem[r] <= '0;
            for (int s = 0; s < SYMS; s++) begin
               next_mem[r][s] <= INIT;
            end
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (row_hit[r]) begin
               if (sel == CFG_SEL_NEXT) begin
                  next_mem[r][wr_sym] <= wr_data[STATE_W-1:0];
               end else begin
                  out_mem[r] <= wr_data[OUT_W-1:0];
               end
            end
         end
      end
   end

   // Sticky error: set by any rejected write, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (we && !wr_ok) begin
         err <= 1'b1;
      end
   end

   // Asynchronous reads; a step sees the pre-write value in the write cycle
   assign rd_next = next_mem[rd_state][rd_sym];
   assign rd_out  = out_mem[rd_state];

endmodule

// File: rtl/prog_moore_fsm.sv
// Table-driven, run-time programmable Moore FSM.
// Holds the state register, saturating transition counter and
// restart/step priority; tables live in prog_fsm_table.
module prog_moore_fsm
   import prog_fsm_pkg::*;
#(
   parameter int STATE_W    = 2,
   parameter int NUM_STATES = 4,
   parameter int IN_W       = 1,
   parameter int OUT_W      = 1,
   parameter int INIT_STATE = 0,
   parameter int CNT_W      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                restart,
   input  logic [IN_W-1:0]     in_sym,
   prog_moore_fsm_if.slave     cfg,
   output logic [OUT_W-1:0]    out_sym,
   output logic [STATE_W-1:0]  state,
   output logic                cfg_err,
   output logic [CNT_W-1:0]    trans_cnt
);

   localparam int                 DATA_W = max_w(STATE_W, OUT_W);
   localparam logic [STATE_W:0]   NS     = (STATE_W + 1)'(NUM_STATES);
   localparam logic [STATE_W-1:0] INIT   = STATE_W'(INIT_STATE);

   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [CNT_W-1:0]   cnt_next;
   logic [STATE_W-1:0] tbl_next;
   logic [OUT_W-1:0]   tbl_out;
   logic               state_legal;

   prog_fsm_table #(
      .STATE_W    (STATE_W),
      .NUM_STATES (NUM_STATES),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .INIT_STATE (INIT_STATE),
      .DATA_W     (DATA_W)
   ) u_table (
      .clk      (clk),
      .reset    (reset),
      .we       (cfg.cfg_we),
      .sel      (cfg.cfg_sel),
      .wr_state (cfg.cfg_state),
      .wr_sym   (cfg.cfg_sym),
      .wr_data  (cfg.cfg_data),
      .rd_state (state_reg),
      .rd_sym   (in_sym),
      .rd_next  (tbl_next),
      .rd_out   (tbl_out),
      .err      (cfg_err)
   );

   // Unreachable through checked writes, but guard against it anyway
   assign state_legal = ({1'b0, state_reg} < NS);

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= INIT;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next state: restart beats step; only real state changes are counted
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (restart) begin
         state_next = INIT;
         cnt_next   = '0;
      end else if (en) begin
         state_next = state_legal ? tbl_next : INIT;
         if ((state_next != state_reg) && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   // Moore output: decoded from the registered state only
   always_comb begin
      out_sym = '0;
      if (state_legal) begin
         out_sym = tbl_out;
      end
   end

   assign state     = state_reg;
   assign trans_cnt = cnt_reg;

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Self-checking bench for prog_moore_fsm: two instances (4 states / 8-bit
// counter and 3 states / 2-bit counter) checked against a table model.
module tb_prog_moore_fsm;
   import prog_fsm_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       en_a, restart_a, en_b, restart_b;
   logic [0:0] sym_a, sym_b, out_a, out_b;
   logic [1:0] state_a, state_b;
   logic       err_a, err_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   prog_moore_fsm_if #(.STATE_W(2), .IN_W(1), .OUT_W(1)) cfg_a ();
   prog_moore_fsm_if #(.STATE_W(2), .IN_W(1), .OUT_W(1)) cfg_b ();

   prog_moore_fsm #(.STATE_W(2), .NUM_STATES(4), .IN_W(1), .OUT_W(1),
                    .INIT_STATE(0), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .en(en_a), .restart(restart_a), .in_sym(sym_a),
      .cfg(cfg_a), .out_sym(out_a), .state(state_a), .cfg_err(err_a), .trans_cnt(cnt_a)
   );

   prog_moore_fsm #(.STATE_W(2), .NUM_STATES(3), .IN_W(1), .OUT_W(1),
                    .INIT_STATE(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .restart(restart_b), .in_sym(sym_b),
      .cfg(cfg_b), .out_sym(out_b), .state(state_b), .cfg_err(err_b), .trans_cnt(cnt_b)
   );

   // Reference model: plain tables per instance
   int m_next [2][4][2];
   int m_out  [2][4];
   int m_state[2];
   int m_cnt  [2];
   int m_err  [2];
   int m_ns   [2] = '{4, 3};
   int m_cmax [2] = '{255, 3};

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      vectors++;
      assert (obs === 32'(exp)) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
         for (int r = 0; r < 4; r++) begin
            m_out[d][r] = 0;
            for (int s = 0; s < 2; s++) m_next[d][r][s] = 0;
         end
      end
   endtask

   task automatic idle();
      en_a = 0; restart_a = 0; sym_a = '0;
      en_b = 0; restart_b = 0; sym_b = '0;
      cfg_a.cfg_we = 0; cfg_a.cfg_sel = 0; cfg_a.cfg_state = '0; cfg_a.cfg_sym = '0; cfg_a.cfg_data = '0;
      cfg_b.cfg_we = 0; cfg_b.cfg_sel = 0; cfg_b.cfg_state = '0; cfg_b.cfg_sym = '0; cfg_b.cfg_data = '0;
   endtask

   task automatic check_now(input int d);
      logic [31:0] st, ou, ct, er;
      int exp_out;
      if (d == 0) begin
         st = {30'b0, state_a}; ou = {31'b0, out_a}; ct = {24'b0, cnt_a}; er = {31'b0, err_a};
      end else begin
         st = {30'b0, state_b}; ou = {31'b0, out_b}; ct = {30'b0, cnt_b}; er = {31'b0, err_b};
      end
      exp_out = (m_state[d] >= m_ns[d]) ? 0 : m_out[d][m_state[d]];
      $display("dut%0d state=%0d out=%0d cnt=%0d err=%0d", d, st, ou, ct, er);
      chk($sformatf("dut%0d_state", d), st, m_state[d]);
      chk($sformatf("dut%0d_out", d), ou, exp_out);
      chk($sformatf("dut%0d_cnt", d), ct, m_cnt[d]);
      chk($sformatf("dut%0d_err", d), er, m_err[d]);
   endtask

   // One clock of activity on instance d, model update, then check
   task automatic step(input int d, input int e, input int rs, input int sym,
                       input int we, input int sel, input int cst, input int csym, input int cdata);
      int nxt;
      idle();
      if (d == 0) begin
         en_a = e[0]; restart_a = rs[0]; sym_a = sym[0:0];
         cfg_a.cfg_we = we[0]; cfg_a.cfg_sel = sel[0]; cfg_a.cfg_state = cst[1:0];
         cfg_a.cfg_sym = csym[0:0]; cfg_a.cfg_data = cdata[1:0];
      end else begin
         en_b = e[0]; restart_b = rs[0]; sym_b = sym[0:0];
         cfg_b.cfg_we = we[0]; cfg_b.cfg_sel = sel[0]; cfg_b.cfg_state = cst[1:0];
         cfg_b.cfg_sym = csym[0:0]; cfg_b.cfg_data = cdata[1:0];
      end
      // step uses the table as it was before this cycle's write
      if (rs[0]) begin
         m_state[d] = 0; m_cnt[d] = 0;
      end else if (e[0]) begin
         nxt = (m_state[d] >= m_ns[d]) ? 0 : m_next[d][m_state[d]][sym & 1];
         if (nxt != m_state[d] && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
         m_state[d] = nxt;
      end
      if (we[0]) begin
         if ((cst & 3) >= m_ns[d] || (sel[0] == 1'b0 && (cdata & 3) >= m_ns[d])) m_err[d] = 1;
         else if (sel[0] == 1'b0) m_next[d][cst & 3][csym & 1] = cdata & 3;
         else m_out[d][cst & 3] = cdata & 1;
      end
      @(posedge clk);
      #1;
      check_now(d);
      idle();
   endtask

   task automatic wr(input int d, input int sel, input int cst, input int csym, input int cdata);
      step(d, 0, 0, 0, 1, sel, cst, csym, cdata);
   endtask

   task automatic go(input int d, input int sym);
      step(d, 1, 0, sym, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int syms1 [5] = '{0, 1, 0, 1, 1};
      int exp_s [5] = '{1, 3, 2, 3, 0};
      int exp_o [5] = '{1, 0, 1, 0, 0};
      int prog  [4][3] = '{'{1, 2, 0}, '{2, 3, 1}, '{1, 3, 1}, '{2, 0, 0}};

      idle();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_now(0);
      check_now(1);
      @(negedge clk);
      reset = 1'b1;

      // Classic 4-state program on instance 0
      for (int r = 0; r < 4; r++) begin
         wr(0, CFG_SEL_NEXT, r, 0, prog[r][0]);
         wr(0, CFG_SEL_NEXT, r, 1, prog[r][1]);
         wr(0, CFG_SEL_OUT,  r, 0, prog[r][2]);
      end
      for (int i = 0; i < 5; i++) begin
         go(0, syms1[i]);
         chk("p1_state", {30'b0, state_a}, exp_s[i]);
         chk("p1_out", {31'b0, out_a}, exp_o[i]);
      end
      chk("p1_cnt", {24'b0, cnt_a}, 5);

      // Hold with en=0 in mid-sequence
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      go(0, 0);
      go(0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0);
      chk("p2_hold_state", {30'b0, state_a}, 3);
      go(0, 0);
      go(0, 1);
      go(0, 1);

      // Write and step on the same entry in the same cycle
      go(0, 0);
      step(0, 1, 0, 0, 1, CFG_SEL_NEXT, 1, 0, 3);
      chk("p3_old_entry", {30'b0, state_a}, 2);
      go(0, 0);
      go(0, 0);
      chk("p3_new_entry", {30'b0, state_a}, 3);

      // Rejected writes on the 3-state instance
      wr(1, CFG_SEL_OUT, 3, 0, 1);
      chk("p4_err_row", {31'b0, err_b}, 1);
      wr(1, CFG_SEL_NEXT, 0, 0, 3);
      go(1, 0);
      chk("p4_reject_data", {30'b0, state_b}, 0);

      // Counter saturation at 2 bits, restart keeps the table
      wr(1, CFG_SEL_NEXT, 0, 0, 1);
      wr(1, CFG_SEL_NEXT, 1, 0, 2);
      wr(1, CFG_SEL_NEXT, 2, 0, 0);
      wr(1, CFG_SEL_OUT, 1, 0, 1);
      for (int i = 0; i < 5; i++) go(1, 0);
      chk("p5_sat", {30'b0, cnt_b}, 3);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      go(1, 0);
      chk("p5_table_kept", {30'b0, state_b}, 1);
      chk("p4_err_sticky", {31'b0, err_b}, 1);

      // Randomized traffic on both instances
      for (int i = 0; i < 400; i++) begin
         int d;
         d = int'($urandom_range(0, 1));
         step(d, ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 15) == 0) ? 1 : 0,
              $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
      end

      // Asynchronous reset in mid-operation
      wr(0, CFG_SEL_OUT, 1, 0, 1);
      wr(0, CFG_SEL_NEXT, 0, 0, 1);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      go(0, 0);
      wr(1, CFG_SEL_OUT, 3, 0, 1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("p6_state", {30'b0, state_a}, 0);
      chk("p6_out", {31'b0, out_a}, 0);
      chk("p6_err", {31'b0, err_b}, 0);
      check_now(0);
      check_now(1);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) go(0, $urandom_range(0, 1));
      for (int i = 0; i < 3; i++) go(1, $urandom_range(0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_moore_fsm.md
Name: prog_moore_fsm

Overview:
A table-driven, run-time programmable Moore state machine that generalises the team's fixed 4-state, 1-bit-input FSMs. The next-state and output tables live in internal registers loaded through a simple configuration write port. State width, input-symbol width and output width are parametrised. It replaces hand-coded small controllers and pattern detectors in lab and datapath designs, and adds step enable, soft restart, write-error checking and a transition counter.

Parameters:
STATE_W, 2, state-register width; the table holds 2**STATE_W state rows
NUM_STATES, 4, number of legal states (2 to 2**STATE_W); states at or above this value are illegal
IN_W, 1, input-symbol width; each state row has 2**IN_W next-state entries
OUT_W, 1, Moore output width per state
INIT_STATE, 0, state entered on reset and on restart; must be < NUM_STATES
CNT_W, 8, transition-counter width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
en  in  1  step enable; state advances only when 1
restart  in  1  synchronous soft return to INIT_STATE
in_sym  in  IN_W  input symbol sampled at posedge when en=1
cfg_we  in  1  configuration write strobe, single cycle
cfg_sel  in  1  0 = write next-state entry, 1 = write output entry
cfg_state  in  STATE_W  table row to write
cfg_sym  in  IN_W  input-symbol column; used only when cfg_sel=0
cfg_data  in  max(STATE_W,OUT_W)  write data; low STATE_W or low OUT_W bits are used
out_sym  out  OUT_W  Moore output, = out_table[state]
state  out  STATE_W  current state
cfg_err  out  1  sticky error flag for a rejected write
trans_cnt  out  CNT_W  count of steps that changed state, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT_STATE, trans_cnt=0, cfg_err=0
  - every next-state entry = INIT_STATE; every output entry = 0, so out_sym=0 after reset
- Priority at each posedge: restart > step. Config writes are independent of both.
- restart=1: state<=INIT_STATE and trans_cnt<=0. Table contents and cfg_err are unchanged.
- Step (en=1, restart=0):
  - state <= next_table[state][in_sym]
  - If the new state differs from the old one, trans_cnt increments, saturating at 2**CNT_W-1.
  - A self-loop does not count.
- en=0: state and trans_cnt hold; in_sym is ignored.
- out_sym is a combinational decode of the registered state and the output table.
  - No latency beyond the state register: out_sym reflects the new state in the same cycle the state changes.
  - It never depends on in_sym.
- Config write (cfg_we=1) takes effect at the posedge:
  - cfg_sel=0: next_table[cfg_state][cfg_sym] <= cfg_data[STATE_W-1:0]
  - cfg_sel=1: out_table[cfg_state] <= cfg_data[OUT_W-1:0]
  - Rejected (no table change, cfg_err<=1) if cfg_state >= NUM_STATES, or if cfg_sel=0 and the data value >= NUM_STATES.
  - cfg_err clears only on reset.
- Simultaneous write and step to the same entry: the step uses the pre-write value; the new value applies from the next cycle.
- Writing the output entry of the current state: out_sym changes right after that edge (Moore, table-sourced).
- Illegal state (only reachable with NUM_STATES < 2**STATE_W and a corrupted table): impossible by construction because writes are range-checked. If it occurs anyway, the next step forces INIT_STATE and out_sym=0.
- Reset asserted mid-operation: immediate return to reset values, including the table. Any write in that cycle is lost.

Decomposition:
- Package prog_fsm_pkg holds:
  - CFG_SEL_NEXT=0 and CFG_SEL_OUT=1
  - a helper function max_w(a,b) for the cfg_data width
- Sub-module prog_fsm_table holds:
  - the register array with one write port, range checking and the error output
  - two asynchronous read ports: next entry by (state, in_sym) and output entry by state
- The top level holds the state register, counter and priority logic.

Test Plan:
1. Program a classic 4-state machine: row 0: 0→1, 1→2, out 0; row 1: 0→2, 1→3, out 1; row 2: 0→1, 1→3, out 1; row 3: 0→2, 1→0, out 0. Drive in_sym 0,1,0,1,1 with en=1 → state 1,3,2,3,0; out_sym 1,0,1,0,0; trans_cnt=5.
2. Same program with en=0 for 3 cycles mid-sequence → state and trans_cnt hold, out_sym stable; the sequence then resumes.
3. Write next entry row 1 col 0 = 3 in the same cycle a step reads row 1 col 0 (old value 2) → state=2 that cycle; the next visit to row 1 with in_sym=0 goes to 3.
4. NUM_STATES=3: write cfg_state=3 → cfg_err=1, table unchanged; write data=3 to row 0 → rejected; cfg_err stays 1 until reset.
5. CNT_W=2: after 5 state changes trans_cnt=3 (saturated); restart → state=INIT_STATE, trans_cnt=0, table intact.
6. Assert reset mid-sequence → state=0, out_sym=0, cfg_err=0 immediately; after release, every step with en=1 keeps state=0 and trans_cnt=0.
